ahb_arbiter_m4: RTL and testbench

Four-master AHB bus arbiter that owns the shared master-side address/control/write-data path feeding the slave-select demultiplexer. Samples per-master bus requests and lock requests, issues a one-hot grant, and publishes the address-phase owner (HMASTER) and the data-phase owner (HMASTER_D) that steer the master-side multiplexers. Re-arbitration is round-robin. It is suppressed during fixed-length bursts and locked sequences. An idle bus is parked on a default master.

---
 rtl/ahb_arbiter_m4_if.sv | 23 ++
 rtl/ahb_arbiter_m4.sv | 131 +++++++++++++
 tb/tb_ahb_arbiter_m4.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_m4_if.sv
// Arbiter-facing AHB signals: request/lock inputs, multiplexed transfer info and grant outputs.
// The slave modport is the arbiter view; the master modport is the bus/master side.
interface ahb_arbiter_m4_if;
  logic [3:0] hbusreqx;
  logic [3:0] hlockx;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrantx;
  logic [3:0] hmaster;
  logic [3:0] hmaster_d;
  logic       hmastlock;

  modport slave (
    input  hbusreqx, hlockx, htrans, hburst, hready,
    output hgrantx, hmaster, hmaster_d, hmastlock
  );

  modport master (
    output hbusreqx, hlockx, htrans, hburst, hready,
    input  hgrantx, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter_m4.sv
// Four-master AHB arbiter: round-robin grant that is frozen during fixed-length bursts and
// locked sequences, with address-phase and data-phase owner indices for the bus muxes.
module ahb_arbiter_m4 #(
  parameter logic [1:0] DEFAULT_MASTER = 2'd0
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_arbiter_m4_if.slave bus
);
  typedef enum logic [1:0] {ARB = 2'd0, BURST = 2'd1, LOCK = 2'd2} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic [3:0] hgrant_r, grant_nxt_s;
  logic [3:0] hmaster_r, hmaster_d_r;
  logic       hmastlock_r;
  logic [1:0] owner_s;
  logic       lk_s;

  function automatic logic [1:0] grant_idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Remaining address beats after the NONSEQ beat; INCR is unbounded so it counts as 0.
  function automatic logic [3:0] burst_rem(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] rr_pick(input logic [1:0] owner, input logic [3:0] req);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = DEFAULT_MASTER;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = owner + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign owner_s = grant_idx(hgrant_r);
  assign lk_s    = bus.hlockx[owner_s] & bus.hbusreqx[owner_s];

  // Next counter, state and grant; everything holds while hready is low.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    grant_nxt_s = hgrant_r;
    if (bus.hready) begin
      case (bus.htrans)
        TR_NONSEQ: cnt_nxt_s = burst_rem(bus.hburst);
        TR_SEQ: begin
          if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        TR_IDLE:   cnt_nxt_s = 4'd0;
        default:   cnt_nxt_s = cnt_r;
      endcase
      if (lk_s) begin
        state_nxt_s = LOCK;
      end else if (cnt_nxt_s != 4'd0) begin
        state_nxt_s = BURST;
      end else begin
        state_nxt_s = ARB;
      end
      if (state_nxt_s == ARB) begin
        grant_nxt_s = 4'b0001 << rr_pick(owner_s, bus.hbusreqx);
      end else begin
        grant_nxt_s = hgrant_r;
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      state_nxt_s = state_r;
      grant_nxt_s = hgrant_r;
    end
  end

  // State, grant and owner pipeline registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r     <= ARB;
      cnt_r       <= 4'd0;
      hgrant_r    <= 4'b0001 << DEFAULT_MASTER;
      hmaster_r   <= {2'b00, DEFAULT_MASTER};
      hmaster_d_r <= {2'b00, DEFAULT_MASTER};
      hmastlock_r <= 1'b0;
    end else if (bus.hready) begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hgrant_r    <= grant_nxt_s;
      hmaster_r   <= {2'b00, owner_s};
      hmaster_d_r <= hmaster_r;
      hmastlock_r <= bus.hlockx[owner_s];
    end else begin
      state_r     <= state_r;
      cnt_r       <= cnt_r;
      hgrant_r    <= hgrant_r;
      hmaster_r   <= hmaster_r;
      hmaster_d_r <= hmaster_d_r;
      hmastlock_r <= hmastlock_r;
    end
  end

  assign bus.hgrantx   = hgrant_r;
  assign bus.hmaster   = hmaster_r;
  assign bus.hmaster_d = hmaster_d_r;
  assign bus.hmastlock = hmastlock_r;
endmodule

// File: tb/tb_ahb_arbiter_m4.sv
// Scoreboard bench for ahb_arbiter_m4: a behavioural model pushes expected outputs per edge,
// a monitor pops and compares them just after each rising edge.
module tb_ahb_arbiter_m4;
  localparam logic [1:0] DM = 2'd2;

  logic hclk = 1'b0;
  logic hreset;
  ahb_arbiter_m4_if bus_if();

  ahb_arbiter_m4 #(.DEFAULT_MASTER(DM)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus_if)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] hm;
    logic [3:0] hmd;
    logic       lock;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Model state: integers for owners and remaining burst beats.
  int m_owner, m_hm, m_hmd, m_cnt;
  bit m_lock;
  int beats_tbl[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic model_step();
    int  next_cnt;
    int  pick;
    bit  lk;
    exp_t e;
    if (hreset) begin
      m_owner = DM; m_hm = DM; m_hmd = DM; m_lock = 1'b0; m_cnt = 0;
    end else if (bus_if.hready) begin
      lk = bus_if.hlockx[m_owner] && bus_if.hbusreqx[m_owner];
      case (bus_if.htrans)
        2'b10:   next_cnt = beats_tbl[bus_if.hburst] - 1;
        2'b11:   next_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        2'b00:   next_cnt = 0;
        default: next_cnt = m_cnt;
      endcase
      m_hmd  = m_hm;
      m_hm   = m_owner;
      m_lock = bus_if.hlockx[m_owner];
      if (!lk && next_cnt == 0) begin
        pick = DM;
        for (int k = 1; k <= 4; k++) begin
          if (bus_if.hbusreqx[(m_owner + k) % 4]) begin
            pick = (m_owner + k) % 4;
            break;
          end
        end
        m_owner = pick;
      end
      m_cnt = next_cnt;
    end
    e.grant = 4'b0001 << m_owner;
    e.hm    = 4'(m_hm);
    e.hmd   = 4'(m_hmd);
    e.lock  = m_lock;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] hb, input bit rdy);
    @(negedge hclk);
    hreset          = rst;
    bus_if.hbusreqx = req;
    bus_if.hlockx   = lck;
    bus_if.htrans   = tr;
    bus_if.hburst   = hb;
    bus_if.hready   = rdy;
    model_step();
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check4("hgrantx",   bus_if.hgrantx,   e.grant);
        check4("hmaster",   bus_if.hmaster,   e.hm);
        check4("hmaster_d", bus_if.hmaster_d, e.hmd);
        check4("hmastlock", {3'b000, bus_if.hmastlock}, {3'b000, e.lock});
      end
    end
  end

  initial begin
    hreset          = 1'b1;
    bus_if.hbusreqx = 4'h0;
    bus_if.hlockx   = 4'h0;
    bus_if.htrans   = 2'b00;
    bus_if.hburst   = 3'd0;
    bus_if.hready   = 1'b1;

    repeat (2) drive(1'b1, 4'h0, 4'h0, 2'b00, 3'd0, 1'b1);
    // Idle bus stays parked on the default master.
    repeat (10) drive(1'b0, 4'h0, 4'h0, 2'b00, 3'd0, 1'b1);
    // All masters requesting with SINGLE transfers: grant rotates every cycle.
    repeat (8) drive(1'b0, 4'hF, 4'h0, 2'b10, 3'd0, 1'b1);
    // INCR4 with a competing request, then the same burst with a 2-cycle stall.
    drive(1'b0, 4'b1010, 4'h0, 2'b10, 3'd3, 1'b1);
    repeat (3) drive(1'b0, 4'b1010, 4'h0, 2'b11, 3'd3, 1'b1);
    drive(1'b0, 4'b1010, 4'h0, 2'b10, 3'd3, 1'b1);
    drive(1'b0, 4'b1010, 4'h0, 2'b11, 3'd3, 1'b1);
    repeat (2) drive(1'b0, 4'b1010, 4'h0, 2'b11, 3'd3, 1'b0);
    repeat (3) drive(1'b0, 4'b1010, 4'h0, 2'b11, 3'd3, 1'b1);
    // Locked sequence from master 0 against competing requests, then release.
    repeat (8) drive(1'b0, 4'hF, 4'b0001, 2'b10, 3'd0, 1'b1);
    repeat (4) drive(1'b0, 4'hF, 4'b0000, 2'b10, 3'd0, 1'b1);
    // Reset in the middle of an INCR8, then a fresh SINGLE from master 1.
    drive(1'b0, 4'b1000, 4'h0, 2'b10, 3'd5, 1'b1);
    drive(1'b0, 4'b1000, 4'h0, 2'b11, 3'd5, 1'b1);
    drive(1'b1, 4'b1000, 4'h0, 2'b11, 3'd5, 1'b1);
    repeat (3) drive(1'b0, 4'b0010, 4'h0, 2'b10, 3'd0, 1'b1);

    // Randomised traffic: bursts, stalls, sparse locks and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 150) == 0,
            4'($urandom),
            (($urandom % 4) == 0) ? 4'($urandom) : 4'h0,
            2'($urandom),
            3'($urandom),
            ($urandom % 5) != 0);
    end

    @(negedge hclk);
    @(negedge hclk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
